// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (read-only) and the memory stage.
// Data side has priority; store lanes are steered out, load lanes aligned and extended back.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [0:ADDR_W-1] i_addr,
  output logic [0:31]     i_data,
  output logic            i_valid,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [0:ADDR_W-1] d_addr,
  input  logic [0:31]     d_wdata,
  input  logic [0:1]      d_size,
  input  logic            d_sign,
  output logic [0:31]     d_rdata,
  output logic            d_valid,
  output logic            d_misalign,
  output logic            d_stall,
  output logic            m_req,
  output logic            m_we,
  output logic [0:ADDR_W-1] m_addr,
  output logic [0:31]     m_wdata,
  output logic [0:3]      m_be,
  input  logic [0:31]     m_rdata,
  input  logic            m_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t      state, state_nxt;
  logic        side_d;
  logic        we_q;
  logic        mis_q;
  logic [0:1]  size_q;
  logic        sign_q;
  logic [0:1]  off_q;
  logic [0:1]  off;
  logic        misalign;
  logic [0:31] st_wdata;
  logic [0:3]  st_be;

  // Byte offset within the word; bit ADDR_W-1 is the address LSB.
  assign off      = d_addr[ADDR_W-2:ADDR_W-1];
  assign misalign = ((d_size == 2'b01) && off[1]) || (d_size[0] && (off != 2'b00));

  function automatic logic [0:31] load_align(input logic [0:31] r, input logic [0:1] sz,
                                             input logic sg, input logic [0:1] k);
    logic [0:7]  b;
    logic [0:15] h;
    b = r[8*int'(k) +: 8];
    h = k[0] ? r[16:31] : r[0:15];
    case (sz)
      2'b00:   load_align = {{24{sg & b[0]}}, b};
      2'b01:   load_align = {{16{sg & h[0]}}, h};
      default: load_align = r;
    endcase
  endfunction

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = d_wdata;
    if (!d_we) begin
      st_be    = 4'b1111;
      st_wdata = '0;
    end else begin
      case (d_size)
        2'b00: begin
          st_wdata = {4{d_wdata[24:31]}};
          st_be[off] = 1'b1;
        end
        2'b01: begin
          st_wdata = {2{d_wdata[16:31]}};
          st_be    = off[0] ? 4'b0011 : 4'b1100;
        end
        default: st_be = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req)      state_nxt = misalign ? RESP : BUSY_D;
        else if (i_req) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: if (m_ready) state_nxt = RESP;
      default:        state_nxt = IDLE;
    endcase
  end

  // Transaction fields are latched at grant and held through BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      side_d  <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= 4'b0000;
      i_data  <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            side_d  <= 1'b1;
            we_q    <= d_we & ~misalign;
            mis_q   <= misalign;
            size_q  <= d_size;
            sign_q  <= d_sign;
            off_q   <= off;
            m_addr  <= {d_addr[0:ADDR_W-3], 2'b00};
            m_wdata <= st_wdata;
            m_be    <= st_be;
            if (misalign) d_rdata <= '0;
          end else if (i_req) begin
            side_d  <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            m_addr  <= {i_addr[0:ADDR_W-3], 2'b00};
            m_wdata <= '0;
            m_be    <= 4'b1111;
          end
        end
        BUSY_I: if (m_ready) i_data  <= m_rdata;
        BUSY_D: if (m_ready) d_rdata <= load_align(m_rdata, size_q, sign_q, off_q);
        default: ;
      endcase
    end
  end

  assign m_req      = (state == BUSY_I) || (state == BUSY_D);
  assign m_we       = we_q && (state == BUSY_D);
  assign i_valid    = (state == RESP) && !side_d;
  assign d_valid    = (state == RESP) && side_d;
  assign d_misalign = d_valid && mis_q;
  assign i_stall    = i_req && !i_valid;
  assign d_stall    = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, priority, load extension, store steering, misalign.
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [0:AW-1] i_addr = '0;
  logic [0:31]   i_data;
  logic          i_valid, i_stall;
  logic          d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
  logic [0:AW-1] d_addr = '0;
  logic [0:31]   d_wdata = '0;
  logic [0:1]    d_size = 2'b00;
  logic [0:31]   d_rdata;
  logic          d_valid, d_misalign, d_stall;
  logic          m_req, m_we;
  logic [0:AW-1] m_addr;
  logic [0:31]   m_wdata;
  logic [0:3]    m_be;
  logic [0:31]   m_rdata = '0;
  logic          m_ready = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_rdata(d_rdata), .d_valid(d_valid), .d_misalign(d_misalign),
    .d_stall(d_stall), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle n cycles in BUSY, then complete with rd; returns sampled in RESP.
  task automatic serve(input int n, input logic [0:31] rd);
    repeat (n) tick();
    m_ready = 1'b1;
    m_rdata = rd;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic load(input string tag, input logic [0:31] addr, input logic [0:1] sz,
                      input logic sg, input logic [0:31] rd, input logic [0:31] exp);
    d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_size = sz; d_sign = sg;
    tick();
    chk({tag, " m_req"}, 32'(m_req), 32'd1);
    chk({tag, " m_be"}, 32'(m_be), 32'hF);
    serve(1, rd);
    chk({tag, " d_valid"}, 32'(d_valid), 32'd1);
    chk({tag, " d_rdata"}, d_rdata, exp);
    d_req = 1'b0;
    tick();
  endtask

  task automatic store(input string tag, input logic [0:31] addr, input logic [0:1] sz,
                       input logic [0:31] wd, input logic [0:31] ea, input logic [0:31] ew,
                       input logic [0:3] eb);
    d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_size = sz; d_wdata = wd;
    tick();
    chk({tag, " m_addr"}, m_addr, ea);
    chk({tag, " m_wdata"}, m_wdata, ew);
    chk({tag, " m_be"}, 32'(m_be), 32'(eb));
    chk({tag, " m_we"}, 32'(m_we), 32'd1);
    serve(0, 32'h0);
    chk({tag, " d_valid"}, 32'(d_valid), 32'd1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk({tag, " m_we idle"}, 32'(m_we), 32'd0);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst m_req", 32'(m_req), 32'd0);
    chk("rst m_be", 32'(m_be), 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk("rst m_wdata", m_wdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst i_data", i_data, 32'd0);
    chk("rst valids", 32'({i_valid, d_valid, d_misalign}), 32'd0);
    i_req = 1'b1; #1;
    chk("rst i_stall", 32'(i_stall), 32'd1);
    i_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset mid-BUSY_D
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_size = 2'b10;
    tick();
    chk("mid m_req busy", 32'(m_req), 32'd1);
    #2 reset = 1'b0; #1;
    chk("mid m_req", 32'(m_req), 32'd0);
    chk("mid m_be", 32'(m_be), 32'd0);
    chk("mid d_valid", 32'(d_valid), 32'd0);
    d_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post m_req", 32'(m_req), 32'd0);
    chk("post d_valid", 32'(d_valid), 32'd0);
    tick();
    chk("post2 valids", 32'({i_valid, d_valid}), 32'd0);

    // Fetch alone
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    chk("fetch m_req", 32'(m_req), 32'd1);
    chk("fetch m_addr", m_addr, 32'h100);
    chk("fetch m_be", 32'(m_be), 32'hF);
    chk("fetch m_we", 32'(m_we), 32'd0);
    chk("fetch i_stall", 32'(i_stall), 32'd1);
    serve(2, 32'h8C220004);
    chk("fetch i_valid", 32'(i_valid), 32'd1);
    chk("fetch i_data", i_data, 32'h8C220004);
    chk("fetch i_stall resp", 32'(i_stall), 32'd0);
    chk("fetch m_req resp", 32'(m_req), 32'd0);
    i_req = 1'b0;
    tick();
    chk("fetch i_valid drop", 32'(i_valid), 32'd0);

    // Simultaneous requests: data first
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_size = 2'b10; d_sign = 1'b0;
    tick();
    chk("pri m_addr", m_addr, 32'h200);
    chk("pri i_stall", 32'(i_stall), 32'd1);
    serve(1, 32'hDEADBEEF);
    chk("pri d_valid", 32'(d_valid), 32'd1);
    chk("pri d_rdata", d_rdata, 32'hDEADBEEF);
    chk("pri i_valid", 32'(i_valid), 32'd0);
    chk("pri i_stall resp", 32'(i_stall), 32'd1);
    d_req = 1'b0;
    tick();
    chk("pri idle m_req", 32'(m_req), 32'd0);
    tick();
    chk("pri fetch m_addr", m_addr, 32'h104);
    chk("pri fetch m_req", 32'(m_req), 32'd1);
    serve(0, 32'h01234567);
    chk("pri fetch i_valid", 32'(i_valid), 32'd1);
    chk("pri fetch i_data", i_data, 32'h01234567);
    i_req = 1'b0;
    tick();

    // Load extraction
    load("lb s", 32'h203, 2'b00, 1'b1, 32'h123456F0, 32'hFFFFFFF0);
    load("lbu", 32'h203, 2'b00, 1'b0, 32'h123456F0, 32'h000000F0);
    load("lh s", 32'h202, 2'b01, 1'b1, 32'h12348001, 32'hFFFF8001);
    load("lbu0", 32'h200, 2'b00, 1'b1, 32'h7F3456F0, 32'h0000007F);
    load("lh0", 32'h200, 2'b01, 1'b0, 32'h9ABC0001, 32'h00009ABC);

    // Store lane steering
    store("sb", 32'h301, 2'b00, 32'h000000AB, 32'h300, 32'hABABABAB, 4'b0100);
    store("sh", 32'h302, 2'b01, 32'h00001234, 32'h300, 32'h12341234, 4'b0011);
    store("sw", 32'h304, 2'b10, 32'hCAFEF00D, 32'h304, 32'hCAFEF00D, 4'b1111);

    // Misaligned word load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h402; d_size = 2'b10;
    tick();
    chk("mis m_req", 32'(m_req), 32'd0);
    chk("mis d_valid", 32'(d_valid), 32'd1);
    chk("mis d_misalign", 32'(d_misalign), 32'd1);
    chk("mis d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    chk("mis drop", 32'({d_valid, d_misalign, m_req}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (load/store), sequencing each access with a request/ready handshake and stalling the losing requester. It also performs byte-lane steering: store-data replication and byte enables on the way out, load alignment and sign/zero extension on the way back. It sits between the memory stage, the fetch stage, and the external memory port.

## Interface
- ADDR_W, 32, address width; data width fixed at 32, bit 0 = MSB, byte 0 = bits [0:7].
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately.
- i_req  in  1  fetch wants the word at i_addr.
- i_addr  in  [0:ADDR_W-1]  fetch address; bits [ADDR_W-2:ADDR_W-1] ignored.
- i_data  out  [0:31]  fetched word, valid while i_valid.
- i_valid  out  1  one-cycle completion pulse for fetch.
- i_stall  out  1  i_req & ~i_valid (combinational).
- d_req  in  1  memory stage access (MemToReg or MemWrite).
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  [0:ADDR_W-1]  byte address.
- d_wdata  in  [0:31]  store data, right-justified (byte in [24:31], half in [16:31]).
- d_size  in  [0:1]  00 byte, 01 half, 10/11 word.
- d_sign  in  1  load sign-extend when 1, zero-extend when 0.
- d_rdata  out  [0:31]  aligned, extended load data, valid while d_valid.
- d_valid  out  1  one-cycle completion pulse for data side.
- d_misalign  out  1  high with d_valid when access was misaligned.
- d_stall  out  1  d_req & ~d_valid (combinational).
- m_req  out  1  memory transaction active.
- m_we  out  1  write strobe.
- m_addr  out  [0:ADDR_W-1]  word address, low two bits always 0.
- m_wdata  out  [0:31]  lane-steered store data.
- m_be  out  [0:3]  byte enables, m_be[k] covers bits [8k:8k+7].
- m_rdata  in  [0:31]  read data, valid in the cycle m_ready is high.
- m_ready  in  1  memory completes the transaction this cycle.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: d_req -> BUSY_D (data priority, older instruction); else i_req -> BUSY_I; else stay. Address/data/be/we registered at grant.
- Misaligned data (half with addr[ADDR_W-1]=1, word with low bits != 00): no memory transaction; IDLE -> RESP with d_valid=1, d_misalign=1, d_rdata=0.
- BUSY_x: m_req=1 and m_addr/m_we/m_wdata/m_be held constant; on m_ready=1 capture processed m_rdata, -> RESP.
- RESP: exactly one cycle; asserts i_valid or d_valid for the granted side only; no grant in RESP; -> IDLE.
- Requesters hold req and fields stable until their valid; changing them mid-transaction is illegal.
- Store lanes: byte -> d_wdata[24:31] replicated to all 4 lanes, m_be one-hot at offset k = addr[ADDR_W-2:ADDR_W-1]; half -> [16:31] replicated to both halves, m_be 1100 (offset 0) or 0011 (offset 2); word -> as-is, 1111.
- Reads (fetch and loads): m_be=1111, m_we=0.
- Load extraction: byte k -> m_rdata[8k:8k+7] into [24:31], upper 24 bits = d_sign ? bit 8k : 0; half offset 0 -> [0:15], offset 2 -> [16:31] into [16:31], upper 16 = d_sign ? MSB : 0; word unchanged.
- Fetch returns m_rdata unmodified.

## Timing
- Reset values: state IDLE; all outputs 0 (i_data, d_rdata, m_addr, m_wdata, m_be = 0); combinational stalls follow reqs.
- Latency: grant edge at cycle 0 -> m_req from cycle 1; m_ready in cycle n (n>=1) -> valid in cycle n+1. Minimum req-to-valid 2 cycles after the IDLE sampling cycle; misaligned completes in 1.
- m_ready while m_req=0 is ignored.
- Simultaneous i_req and d_req in IDLE: data wins; fetch stays stalled and is granted in the IDLE after RESP if still pending and no d_req.
- Requests arriving during BUSY/RESP wait; never granted in RESP, so a req held through its own valid is not reissued.
- Reset asserted mid-transaction: m_req drops asynchronously, no valid is produced, state IDLE.

## Test plan
- Reset mid-BUSY_D (m_req=1): reset low -> m_req, d_valid, m_be = 0 immediately; after release, IDLE with no pending valid.
- Fetch alone, i_addr=0x100, m_ready after 3 cycles with m_rdata=0x8C220004 -> m_addr=0x100, m_be=1111, i_valid one cycle with i_data=0x8C220004.
- Same-cycle i_req and d_req (load word 0x200) -> data transaction first, d_valid, then fetch granted; i_stall high throughout data access.
- Signed byte load, d_addr=0x203, m_rdata=0x123456F0 -> d_rdata=0xFFFFFFF0; same with d_sign=0 -> 0x000000F0; half at 0x202 signed, m_rdata=0x12348001 -> 0xFFFF8001.
- Store byte 0xAB at 0x301 -> m_addr=0x300, m_wdata=0xABABABAB, m_be=0100, m_we=1; store half 0x1234 at 0x302 -> m_wdata=0x12341234, m_be=0011.
- Word load at 0x402 -> no m_req, d_valid and d_misalign one cycle, d_rdata=0.
